spi_mem_slave: RTL and testbench
================================

# spi_mem_slave

Parametrised SPI slave bridging an external SPI master to two on-chip dual-port buffers: a receive buffer written from MOSI and a transmit buffer read out on MISO. Supports all four SPI modes, configurable data-word width and buffer depth, and actively drives MISO, which the previous generation did not. Sits between the board-level SPI pins and the buffer RAMs, with everything in the SysClk domain.

## Interface
- AddrBits, 12: buffer address width; depth 2^AddrBits words.
- WordBits, 8: data word width, 4..32; the command byte is always 8 bits.
- CPOL, 0: SPI clock idle level.
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge.

- SysClk  in  1  system clock; must be at least 8x SPI_CLK.
- Reset  in  1  synchronous, active-high reset.
- SPI_CLK  in  1  asynchronous SPI clock.
- SPI_SS  in  1  asynchronous slave select, active low.
- SPI_MOSI  in  1  master-to-slave data.
- SPI_MISO  out  1  slave-to-master data; 0 when not transmitting.
- txMemAddr  out  AddrBits  transmit buffer read address.
- txMemData  in  WordBits  transmit buffer data; 1-cycle synchronous read.
- rcMemAddr  out  AddrBits  receive buffer write address.
- rcMemData  out  WordBits  receive buffer write data.
- rcMemWE  out  1  receive buffer write strobe; one SysClk per word.
- busy  out  1  synchronised slave select is active.
- irq  out  1  one-cycle interrupt pulse; tied 0 when the feature is compiled out.

## Operation
- SPI_CLK, SPI_SS and SPI_MOSI each pass through a 2-flop synchroniser before use.
- Edge detect runs on the synchronised clock. The sample edge is rising when CPOL^CPHA=0, falling otherwise. The shift edge is the opposite edge.
- A falling edge of synchronised SS does all of the following:
  - bit counter is set to 7;
  - state goes to GET_CMD;
  - MISO is forced to 0.
- States:
  - GET_CMD: shifts in 8 bits, MSB first, then decodes the command byte.
    - 0x01 READ_START: rcMemAddr := 0, go to RECEIVE.
    - 0x02 READ_MORE: rcMemAddr is kept, go to RECEIVE.
    - 0x03 WRITE_START: txMemAddr := 0, go to TRANSMIT.
    - 0x04 WRITE_MORE: txMemAddr is kept, go to TRANSMIT.
    - 0x05 INTERRUPT: see Configuration.
    - Any other byte: go to IGNORE.
  - RECEIVE: each complete WordBits word, MSB first, is written to rcMemAddr. After the write, rcMemAddr increments.
  - TRANSMIT: MISO shifts out the prefetch register, MSB first. Each completed word increments txMemAddr.
  - IGNORE: MISO = 0, no memory activity, until SS rises.
- Address arithmetic is modulo 2^AddrBits, so the address after 2^AddrBits-1 is 0.
- SS rising mid-word:
  - the partial word is discarded and no write occurs;
  - both addresses are retained, so a following *_MORE command resumes from them;
  - state returns to GET_CMD.
- Reset mid-transfer:
  - both addresses, state, bit counter and prefetch register are cleared;
  - the transfer restarts only at the next SS falling edge.

## Timing
- Reset values: txMemAddr=0, rcMemAddr=0, rcMemData=0, rcMemWE=0, SPI_MISO=0, busy=0, irq=0. State = GET_CMD.
- Input latency is 2 SysClk for the synchronisers plus 1 SysClk for the edge register.
- rcMemWE is asserted exactly 1 SysClk after the synchronised sample edge that completes a word. rcMemData and rcMemAddr are stable in that same cycle.
- TRANSMIT prefetch: txMemAddr changes, then txMemData is captured into the prefetch register 2 SysClk later. This completes before the next shift edge, guaranteed by the 8x clock ratio.
- MISO changes only on synchronised shift edges.
  - CPHA=0: the MSB of the first word is driven on the shift edge that ends the command byte.
  - CPHA=1: the MSB of the first word is driven on the first shift edge of the word.
- SS falling and a sample edge in the same SysClk: the bit counter reset wins and the sample is taken as bit 7.

## Configuration
- SPI_IRQ_EN defined: command 0x05 pulses irq high for exactly 1 SysClk, 1 cycle after decode, then the block goes to IGNORE.
- SPI_IRQ_EN undefined: 0x05 is treated as an unknown command (IGNORE) and irq is constant 0.

## Structure
- Package spi_mem_pkg holds:
  - the command code constants CMD_READ_START..CMD_INTERRUPT;
  - the state enum GET_CMD/RECEIVE/TRANSMIT/IGNORE;
  - the width constant CMD_BITS=8.
- Sub-module spi_edge_sync covers the 2-flop synchroniser plus rising/falling edge detect. It is instantiated for SPI_CLK and SPI_SS; MOSI uses the synchroniser only.

## Test plan
- Mode 0, WordBits=8: SS low, send 0x01, 0xA5, 0x3C. Required: rcMemWE pulses twice, writing (addr 0, data 0xA5) then (addr 1, data 0x3C).
- Follow-on: new frame sends 0x02, 0x77. Required: write at addr 2, data 0x77.
- Mode 3, WordBits=16: txMem[0]=0xBEEF, txMem[1]=0x1234, send 0x03 plus 32 clocks. Required: MISO shifts 0xBEEF then 0x1234 and txMemAddr ends at 2.
- Wrap: AddrBits=2, send 0x01 plus 5 words. Required: fifth write lands at addr 0.
- SS rises after 5 bits of a data word. Required: no rcMemWE and rcMemAddr unchanged; Reset asserted mid-frame clears all outputs within 1 cycle.
- Send 0x05, then 0x09. Required: with SPI_IRQ_EN, irq is high for 1 cycle; 0x09 gives IGNORE, MISO stays 0 and there are no writes.

Source files
------------

// File: rtl/spi_mem_pkg.sv
// Shared constants and state type for the SPI-to-buffer bridge.
package spi_mem_pkg;

  localparam int CMD_BITS = 8;

  localparam logic [CMD_BITS-1:0] CMD_READ_START  = 8'h01;
  localparam logic [CMD_BITS-1:0] CMD_READ_MORE   = 8'h02;
  localparam logic [CMD_BITS-1:0] CMD_WRITE_START = 8'h03;
  localparam logic [CMD_BITS-1:0] CMD_WRITE_MORE  = 8'h04;
  localparam logic [CMD_BITS-1:0] CMD_INTERRUPT   = 8'h05;

  typedef enum logic [1:0] {
    GET_CMD,
    RECEIVE,
    TRANSMIT,
    IGNORE
  } spi_state_t;

endpackage

// File: rtl/spi_mem_slave_if.sv
// Buffer-RAM side of the SPI bridge: transmit read port and receive write port.
interface spi_mem_slave_if #(
  parameter int AddrBits = 12,
  parameter int WordBits = 8
) ();

  logic [AddrBits-1:0] txMemAddr;
  logic [WordBits-1:0] txMemData;
  logic [AddrBits-1:0] rcMemAddr;
  logic [WordBits-1:0] rcMemData;
  logic                rcMemWE;

  modport slave (
    output txMemAddr,
    input  txMemData,
    output rcMemAddr,
    output rcMemData,
    output rcMemWE
  );

  modport master (
    input  txMemAddr,
    output txMemData,
    input  rcMemAddr,
    input  rcMemData,
    input  rcMemWE
  );

endinterface

// File: rtl/spi_edge_sync.sv
// Two-flop synchroniser plus history flop; o_edge flags any transition and
// o_sync tells its direction (1 = rising, 0 = falling).
module spi_edge_sync #(
  parameter bit RstVal = 1'b0
) (
  input  logic SysClk,
  input  logic Reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_edge
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge SysClk) begin
    if (Reset) begin
      r_meta <= RstVal;
      r_sync <= RstVal;
      r_prev <= RstVal;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_edge = r_sync ^ r_prev;

endmodule

// File: rtl/spi_mem_slave.sv
// SPI slave bridging an external master to receive/transmit buffer RAMs.
// Optional macro SPI_IRQ_EN enables command 0x05 (one-cycle irq pulse).
module spi_mem_slave
  import spi_mem_pkg::*;
#(
  parameter int AddrBits = 12,
  parameter int WordBits = 8,
  parameter int CPOL     = 0,
  parameter int CPHA     = 0
) (
  input  logic            SysClk,
  input  logic            Reset,
  input  logic            SPI_CLK,
  input  logic            SPI_SS,
  input  logic            SPI_MOSI,
  output logic            SPI_MISO,
  output logic            busy,
  output logic            irq,
  spi_mem_slave_if.slave  mem
);

  localparam int         ShW       = (WordBits > CMD_BITS) ? WordBits : CMD_BITS;
  localparam logic [4:0] CmdLast   = 5'(CMD_BITS - 1);
  localparam logic [4:0] WordLast  = 5'(WordBits - 1);
  localparam bit         SampleLvl = ((CPOL ^ CPHA) == 0);

  logic w_clk_sync, w_clk_edge;
  logic w_ss_sync, w_ss_edge;
  logic w_sample, w_shift, w_ss_fall, w_ss_rise, w_busy;

  spi_edge_sync #(.RstVal(CPOL != 0)) u_clk_sync (
    .SysClk (SysClk),
    .Reset  (Reset),
    .i_async(SPI_CLK),
    .o_sync (w_clk_sync),
    .o_edge (w_clk_edge)
  );

  spi_edge_sync #(.RstVal(1'b1)) u_ss_sync (
    .SysClk (SysClk),
    .Reset  (Reset),
    .i_async(SPI_SS),
    .o_sync (w_ss_sync),
    .o_edge (w_ss_edge)
  );

  logic r_mosi_meta, r_mosi_sync;

  always_ff @(posedge SysClk) begin
    if (Reset) begin
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_mosi_meta <= SPI_MOSI;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  assign w_sample  = w_clk_edge & (w_clk_sync == SampleLvl);
  assign w_shift   = w_clk_edge & (w_clk_sync != SampleLvl);
  assign w_ss_fall = w_ss_edge & ~w_ss_sync;
  assign w_ss_rise = w_ss_edge & w_ss_sync;
  assign w_busy    = ~w_ss_sync;

  spi_state_t          r_state;
  logic [4:0]          r_bit_cnt;
  logic [ShW-2:0]      r_shift;
  logic [AddrBits-1:0] r_rc_addr;
  logic [WordBits-1:0] r_rc_data;
  logic                r_rc_we;
  logic [AddrBits-1:0] r_tx_addr;
  logic [WordBits-1:0] r_prefetch;
  logic [WordBits-1:0] r_tx_shift;
  logic [4:0]          r_tx_cnt;
  logic [1:0]          r_pf_pend;
  logic                r_miso;
`ifdef SPI_IRQ_EN
  logic                r_irq;
`endif

  spi_state_t     w_state_eff;
  logic [4:0]     w_cnt_eff;
  logic [ShW-1:0] w_shift_next;

  // SS falling wins over a coincident sample: that sample becomes bit 7.
  assign w_state_eff  = w_ss_fall ? GET_CMD : r_state;
  assign w_cnt_eff    = w_ss_fall ? CmdLast : r_bit_cnt;
  assign w_shift_next = {r_shift, r_mosi_sync};

  always_ff @(posedge SysClk) begin
    if (Reset) begin
      r_state    <= GET_CMD;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_rc_addr  <= '0;
      r_rc_data  <= '0;
      r_rc_we    <= 1'b0;
      r_tx_addr  <= '0;
      r_prefetch <= '0;
      r_tx_shift <= '0;
      r_tx_cnt   <= '0;
      r_pf_pend  <= '0;
      r_miso     <= 1'b0;
`ifdef SPI_IRQ_EN
      r_irq      <= 1'b0;
`endif
    end else begin
`ifdef SPI_IRQ_EN
      r_irq <= 1'b0;
`endif
      // Prefetch pipe: address out, RAM read cycle, then capture.
      r_pf_pend <= {r_pf_pend[0], 1'b0};
      if (r_pf_pend[1]) begin
        r_prefetch <= mem.txMemData;
      end

      if (r_rc_we) begin
        r_rc_we   <= 1'b0;
        r_rc_addr <= r_rc_addr + AddrBits'(1);
      end

      if (w_ss_rise) begin
        r_state   <= GET_CMD;
        r_bit_cnt <= CmdLast;
        r_miso    <= 1'b0;
      end else if (w_busy) begin
        if (w_ss_fall) begin
          r_state   <= GET_CMD;
          r_bit_cnt <= CmdLast;
          r_miso    <= 1'b0;
        end

        if (w_sample) begin
          r_shift   <= w_shift_next[ShW-2:0];
          r_bit_cnt <= w_cnt_eff - 5'd1;
          case (w_state_eff)
            GET_CMD: begin
              if (w_cnt_eff == '0) begin
                r_bit_cnt <= WordLast;
                case (w_shift_next[CMD_BITS-1:0])
                  CMD_READ_START: begin
                    r_rc_addr <= '0;
                    r_state   <= RECEIVE;
                  end
                  CMD_READ_MORE: r_state <= RECEIVE;
                  CMD_WRITE_START: begin
                    r_tx_addr <= '0;
                    r_pf_pend <= 2'b01;
                    r_tx_cnt  <= '0;
                    r_state   <= TRANSMIT;
                  end
                  CMD_WRITE_MORE: begin
                    r_pf_pend <= 2'b01;
                    r_tx_cnt  <= '0;
                    r_state   <= TRANSMIT;
                  end
`ifdef SPI_IRQ_EN
                  CMD_INTERRUPT: begin
                    r_irq   <= 1'b1;
                    r_state <= IGNORE;
                  end
`endif
                  default: r_state <= IGNORE;
                endcase
              end
            end
            RECEIVE: begin
              if (w_cnt_eff == '0) begin
                r_bit_cnt <= WordLast;
                r_rc_data <= w_shift_next[WordBits-1:0];
                r_rc_we   <= 1'b1;
              end
            end
            TRANSMIT: begin
              if (w_cnt_eff == '0) begin
                r_bit_cnt <= WordLast;
                r_tx_addr <= r_tx_addr + AddrBits'(1);
                r_pf_pend <= 2'b01;
              end
            end
            IGNORE: begin
            end
          endcase
        end

        // First shift edge of each word loads the prefetched word.
        if (w_shift && (w_state_eff == TRANSMIT)) begin
          if (r_tx_cnt == '0) begin
            r_miso     <= r_prefetch[WordBits-1];
            r_tx_shift <= {r_prefetch[WordBits-2:0], 1'b0};
            r_tx_cnt   <= WordLast;
          end else begin
            r_miso     <= r_tx_shift[WordBits-1];
            r_tx_shift <= {r_tx_shift[WordBits-2:0], 1'b0};
            r_tx_cnt   <= r_tx_cnt - 5'd1;
          end
        end
      end
    end
  end

  assign mem.txMemAddr = r_tx_addr;
  assign mem.rcMemAddr = r_rc_addr;
  assign mem.rcMemData = r_rc_data;
  assign mem.rcMemWE   = r_rc_we;
  assign SPI_MISO      = r_miso;
  assign busy          = w_busy;
`ifdef SPI_IRQ_EN
  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_spi_mem_slave.sv
// Bench for spi_mem_slave: DUT A is mode 0 / 8-bit / 4-deep, DUT B is mode 3 / 16-bit.
module tb_spi_mem_slave;
  import spi_mem_pkg::*;

  localparam int HALF = 80;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sclk;
  logic [1:0] ss;
  logic [1:0] mosi;
  wire  [1:0] miso;
  wire  [1:0] busy;
  wire  [1:0] irq;

  int n_checks = 0;
  int n_errors = 0;
  int irq_cnt  = 0;

  wr_t qa[$];
  wr_t qb[$];

  logic [7:0]  txmem_a [4];
  logic [15:0] txmem_b [16];

  always #5 clk = ~clk;

  spi_mem_slave_if #(.AddrBits(2), .WordBits(8))  mem_a ();
  spi_mem_slave_if #(.AddrBits(4), .WordBits(16)) mem_b ();

  spi_mem_slave #(.AddrBits(2), .WordBits(8), .CPOL(0), .CPHA(0)) dut_a (
    .SysClk(clk), .Reset(rst), .SPI_CLK(sclk[0]), .SPI_SS(ss[0]), .SPI_MOSI(mosi[0]),
    .SPI_MISO(miso[0]), .busy(busy[0]), .irq(irq[0]), .mem(mem_a.slave)
  );

  spi_mem_slave #(.AddrBits(4), .WordBits(16), .CPOL(1), .CPHA(1)) dut_b (
    .SysClk(clk), .Reset(rst), .SPI_CLK(sclk[1]), .SPI_SS(ss[1]), .SPI_MOSI(mosi[1]),
    .SPI_MISO(miso[1]), .busy(busy[1]), .irq(irq[1]), .mem(mem_b.slave)
  );

  always @(posedge clk) begin
    mem_a.txMemData <= txmem_a[mem_a.txMemAddr];
    mem_b.txMemData <= txmem_b[mem_b.txMemAddr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Write scoreboards: each rcMemWE pops one expected (addr, data).
  logic we_prev_a = 1'b0;
  logic we_prev_b = 1'b0;

  always @(negedge clk) begin
    wr_t e;
    if (mem_a.rcMemWE) begin
      if (we_prev_a) chk("we_width_a", 32'(we_prev_a), 32'd0);
      if (qa.size() == 0) begin
        chk("unexp_we_a", 32'(mem_a.rcMemWE), 32'd0);
      end else begin
        e = qa.pop_front();
        chk("wr_addr_a", 32'(mem_a.rcMemAddr), e.addr);
        chk("wr_data_a", 32'(mem_a.rcMemData), e.data);
        $display("wr A addr=%0d data=%h", mem_a.rcMemAddr, mem_a.rcMemData);
      end
    end
    if (mem_b.rcMemWE) begin
      if (qb.size() == 0) begin
        chk("unexp_we_b", 32'(mem_b.rcMemWE), 32'd0);
      end else begin
        e = qb.pop_front();
        chk("wr_addr_b", 32'(mem_b.rcMemAddr), e.addr);
        chk("wr_data_b", 32'(mem_b.rcMemData), e.data);
        $display("wr B addr=%0d data=%h", mem_b.rcMemAddr, mem_b.rcMemData);
      end
    end
    if (irq[0]) irq_cnt++;
    we_prev_a = mem_a.rcMemWE;
    we_prev_b = mem_b.rcMemWE;
  end

  task automatic push_a(input int addr, input int data);
    qa.push_back(wr_t'{addr: 32'(addr), data: 32'(data)});
  endtask

  task automatic push_b(input int addr, input int data);
    qb.push_back(wr_t'{addr: 32'(addr), data: 32'(data)});
  endtask

  // DUT 0 is mode 0 (data before rising edge), DUT 1 is mode 3 (data on falling edge).
  task automatic spi_bits(input int d, input int n, input logic [31:0] tx, output logic [31:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (d == 0) begin
        mosi[0] = tx[i];
        #HALF;
        sclk[0] = 1'b1;
        rx[i] = miso[0];
        #HALF;
        sclk[0] = 1'b0;
      end else begin
        sclk[1] = 1'b0;
        mosi[1] = tx[i];
        #HALF;
        sclk[1] = 1'b1;
        rx[i] = miso[1];
        #HALF;
      end
    end
  endtask

  task automatic frame_start(input int d);
    @(negedge clk);
    ss[d] = 1'b0;
    #HALF;
  endtask

  task automatic frame_end(input int d);
    #HALF;
    ss[d] = 1'b1;
    #(4 * HALF);
  endtask

  initial begin
    logic [31:0] rx;
    int          dv;
    int          irq_exp;
    sclk = 2'b10;
    ss   = 2'b11;
    mosi = 2'b00;
    for (int i = 0; i < 4; i++) txmem_a[i] = 8'($urandom_range(1, 255));
    for (int i = 0; i < 16; i++) txmem_b[i] = 16'($urandom);
    txmem_b[0] = 16'hBEEF;
    txmem_b[1] = 16'h1234;
`ifdef SPI_IRQ_EN
    irq_exp = 1;
`else
    irq_exp = 0;
`endif

    repeat (4) @(negedge clk);
    chk("rst_txaddr_a", 32'(mem_a.txMemAddr), 32'd0);
    chk("rst_rcaddr_a", 32'(mem_a.rcMemAddr), 32'd0);
    chk("rst_rcdata_a", 32'(mem_a.rcMemData), 32'd0);
    chk("rst_we_a",     32'(mem_a.rcMemWE),   32'd0);
    chk("rst_miso_a",   32'(miso[0]),         32'd0);
    chk("rst_busy_a",   32'(busy[0]),         32'd0);
    chk("rst_irq_a",    32'(irq[0]),          32'd0);
    chk("rst_txaddr_b", 32'(mem_b.txMemAddr), 32'd0);
    chk("rst_busy_b",   32'(busy[1]),         32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("frame A: READ_START a5 3c");
    push_a(0, 8'hA5);
    push_a(1, 8'h3C);
    frame_start(0);
    spi_bits(0, 8, 32'(CMD_READ_START), rx);
    chk("busy_a", 32'(busy[0]), 32'd1);
    spi_bits(0, 8, 32'hA5, rx);
    chk("miso_rx_a", rx, 32'd0);
    spi_bits(0, 8, 32'h3C, rx);
    frame_end(0);
    chk("rcaddr_t1", 32'(mem_a.rcMemAddr), 32'd2);
    chk("busy_idle_a", 32'(busy[0]), 32'd0);

    $display("frame A: READ_MORE 77");
    push_a(2, 8'h77);
    frame_start(0);
    spi_bits(0, 8, 32'(CMD_READ_MORE), rx);
    spi_bits(0, 8, 32'h77, rx);
    frame_end(0);
    chk("rcaddr_t2", 32'(mem_a.rcMemAddr), 32'd3);

    $display("frame A: READ_START 5 words, wrap");
    frame_start(0);
    spi_bits(0, 8, 32'(CMD_READ_START), rx);
    for (int w = 0; w < 5; w++) begin
      dv = $urandom_range(0, 255);
      push_a(w % 4, dv);
      spi_bits(0, 8, 32'(dv), rx);
    end
    frame_end(0);
    chk("rcaddr_wrap", 32'(mem_a.rcMemAddr), 32'd1);

    $display("frame A: READ_MORE, SS rises after 5 bits");
    frame_start(0);
    spi_bits(0, 8, 32'(CMD_READ_MORE), rx);
    spi_bits(0, 5, 32'h1F, rx);
    frame_end(0);
    chk("rcaddr_partial", 32'(mem_a.rcMemAddr), 32'd1);
    chk("q_partial", 32'(qa.size()), 32'd0);

    $display("frame A: READ_MORE resume");
    push_a(1, 8'hC3);
    frame_start(0);
    spi_bits(0, 8, 32'(CMD_READ_MORE), rx);
    spi_bits(0, 8, 32'hC3, rx);
    frame_end(0);
    chk("rcaddr_resume", 32'(mem_a.rcMemAddr), 32'd2);

    $display("frame A: WRITE_START 2 bytes");
    frame_start(0);
    spi_bits(0, 8, 32'(CMD_WRITE_START), rx);
    spi_bits(0, 8, 32'h00, rx);
    chk("miso_tx_a0", rx, 32'(txmem_a[0]));
    spi_bits(0, 8, 32'h00, rx);
    chk("miso_tx_a1", rx, 32'(txmem_a[1]));
    frame_end(0);
    chk("txaddr_a", 32'(mem_a.txMemAddr), 32'd2);
    chk("miso_idle_a", 32'(miso[0]), 32'd0);

    $display("frame A: WRITE_MORE 1 byte");
    frame_start(0);
    spi_bits(0, 8, 32'(CMD_WRITE_MORE), rx);
    spi_bits(0, 8, 32'h00, rx);
    chk("miso_tx_a2", rx, 32'(txmem_a[2]));
    frame_end(0);
    chk("txaddr_a_more", 32'(mem_a.txMemAddr), 32'd3);

    $display("frame B: WRITE_START 2 words");
    frame_start(1);
    spi_bits(1, 8, 32'(CMD_WRITE_START), rx);
    spi_bits(1, 16, 32'h0, rx);
    chk("miso_tx_b0", rx, 32'hBEEF);
    spi_bits(1, 16, 32'h0, rx);
    chk("miso_tx_b1", rx, 32'h1234);
    frame_end(1);
    chk("txaddr_b", 32'(mem_b.txMemAddr), 32'd2);

    $display("frame B: READ_START cafe");
    push_b(0, 16'hCAFE);
    frame_start(1);
    spi_bits(1, 8, 32'(CMD_READ_START), rx);
    spi_bits(1, 16, 32'hCAFE, rx);
    frame_end(1);
    chk("rcaddr_b", 32'(mem_b.rcMemAddr), 32'd1);

    $display("frame A: INTERRUPT then ff");
    irq_cnt = 0;
    frame_start(0);
    spi_bits(0, 8, 32'(CMD_INTERRUPT), rx);
    spi_bits(0, 8, 32'hFF, rx);
    chk("miso_irq_ign", rx, 32'd0);
    frame_end(0);
    chk("irq_cycles", 32'(irq_cnt), 32'(irq_exp));

    $display("frame A: unknown 09 then ab");
    frame_start(0);
    spi_bits(0, 8, 32'h09, rx);
    spi_bits(0, 8, 32'hAB, rx);
    chk("miso_ignore", rx, 32'd0);
    frame_end(0);
    chk("rcaddr_ignore", 32'(mem_a.rcMemAddr), 32'd2);
    chk("txaddr_ignore", 32'(mem_a.txMemAddr), 32'd3);

    $display("frame A: READ_START 55 then reset mid-word");
    push_a(0, 8'h55);
    frame_start(0);
    spi_bits(0, 8, 32'(CMD_READ_START), rx);
    spi_bits(0, 8, 32'h55, rx);
    spi_bits(0, 3, 32'h5, rx);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_txaddr_a", 32'(mem_a.txMemAddr), 32'd0);
    chk("mrst_rcaddr_a", 32'(mem_a.rcMemAddr), 32'd0);
    chk("mrst_rcdata_a", 32'(mem_a.rcMemData), 32'd0);
    chk("mrst_we_a",     32'(mem_a.rcMemWE),   32'd0);
    chk("mrst_miso_a",   32'(miso[0]),         32'd0);
    chk("mrst_busy_a",   32'(busy[0]),         32'd0);
    chk("mrst_txaddr_b", 32'(mem_b.txMemAddr), 32'd0);
    ss[0]   = 1'b1;
    sclk[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("frame A: READ_MORE 66 after reset");
    push_a(0, 8'h66);
    frame_start(0);
    spi_bits(0, 8, 32'(CMD_READ_MORE), rx);
    spi_bits(0, 8, 32'h66, rx);
    frame_end(0);
    chk("rcaddr_post_rst", 32'(mem_a.rcMemAddr), 32'd1);

    repeat (10) @(negedge clk);
    chk("qa_left", 32'(qa.size()), 32'd0);
    chk("qb_left", 32'(qb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
